// File: rtl/adc_lcd_fmt_pkg.sv
// Shared constants, FSM encoding and the power-on text frame for the ADC-to-LCD formatter.
package lcd_fmt_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int OFS_CH  = 0;
  localparam int OFS_VAL = 2;
  localparam int FIELD_W = 8;
  localparam int NCH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_SHIFT,
    ST_WRITE
  } fmt_state_t;

  // Byte k of the frame sits at bits [8k+7:8k]; each field reads "c:0.000 ".
  function automatic logic [511:0] frame_template();
    logic [511:0] f;
    f = '0;
    for (int c = 0; c < NCH; c++) begin
      f[(c*FIELD_W + OFS_CH)*8 +: 8]      = CH_0 + 8'(c);
      f[(c*FIELD_W + OFS_CH + 1)*8 +: 8]  = CH_COLON;
      f[(c*FIELD_W + OFS_VAL)*8 +: 8]     = CH_0;
      f[(c*FIELD_W + OFS_VAL + 1)*8 +: 8] = CH_DOT;
      f[(c*FIELD_W + OFS_VAL + 2)*8 +: 8] = CH_0;
      f[(c*FIELD_W + OFS_VAL + 3)*8 +: 8] = CH_0;
      f[(c*FIELD_W + OFS_VAL + 4)*8 +: 8] = CH_0;
      f[(c*FIELD_W + 7)*8 +: 8]           = CH_SPACE;
    end
    return f;
  endfunction

endpackage

// File: rtl/adc_lcd_fmt_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, 16 cycles from start to a valid 4-digit BCD result.
module bin2bcd_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [15:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [15:0] w_adj;

  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                          : r_bcd[gi*4 +: 4];
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done = r_busy && (r_cnt == 4'd15);
  assign bcd  = r_bcd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_bin  <= bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= 16'({w_adj, r_bin[15]});
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_lcd_fmt.sv
// Accepts one ADC sample per handshake, scales it to millivolts and rewrites that
// channel's "c:d.ddd " field in the 64-byte LCD text frame.
module adc_lcd_fmt
  import lcd_fmt_pkg::*;
#(
  parameter int VREF_MV = 5000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [3:0]   s_ch,
  input  logic [9:0]   s_code,
  output logic [511:0] disp_chars,
  output logic         upd_pulse
);

  fmt_state_t  r_state;
  fmt_state_t  w_state_next;
  logic        r_ready;
  logic        r_upd;
  logic [511:0] r_disp;
  logic [2:0]  r_ch;
  logic [9:0]  r_code;

  logic        w_accept;
  logic        w_start;
  logic        w_ready_next;
  logic        w_done;
  logic [13:0] w_mv_raw;
  logic [15:0] w_mv;
  logic [15:0] w_bcd;
  logic [63:0] w_field;

  // Full-width product: 1023 x 9999 does not fit in 23 bits.
  assign w_mv_raw = 14'((24'(r_code) * 24'(VREF_MV)) >> 10);
  assign w_mv     = (w_mv_raw > 14'd9999) ? 16'd9999 : {2'b00, w_mv_raw};

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_valid && r_ready) begin
          w_accept     = 1'b1;
          w_state_next = s_ch[3] ? ST_IDLE : ST_MULT;
        end
      end
      ST_MULT: begin
        w_start      = 1'b1;
        w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_done) w_state_next = ST_WRITE;
      end
      ST_WRITE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    // A discarded sample still costs one dead cycle before the next accept.
    w_ready_next = (w_state_next == ST_IDLE) && !w_accept;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_upd   <= 1'b0;
      r_ch    <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
      r_upd   <= (r_state == ST_WRITE);
      if (w_accept) begin
        r_ch   <= s_ch[2:0];
        r_code <= s_code;
      end
    end
  end

  bin2bcd_seq u_bcd (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (w_start),
    .bin   (w_mv),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign w_field = {CH_SPACE,
                    CH_0 + {4'h0, w_bcd[3:0]},
                    CH_0 + {4'h0, w_bcd[7:4]},
                    CH_0 + {4'h0, w_bcd[11:8]},
                    CH_DOT,
                    CH_0 + {4'h0, w_bcd[15:12]},
                    CH_COLON,
                    CH_0 + {5'h00, r_ch}};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_disp <= frame_template();
    end else if (r_state == ST_WRITE) begin
      r_disp[{r_ch, 6'd0} +: 64] <= w_field;
    end
  end

  assign s_ready    = r_ready;
  assign upd_pulse  = r_upd;
  assign disp_chars = r_disp;

endmodule
